// File: rtl/fir_coef_loader_if.sv
// Valid/ready word port carrying coefficient frames from the control path to the loader.
interface fir_coef_loader_if #(
  parameter int DATA_W = 16
);
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;

  modport master (output load_valid, output load_data, input load_ready);
  modport slave  (input load_valid, input load_data, output load_ready);
endinterface

// File: rtl/fir_coef_loader.sv
// Coefficient loader for the 17-tap symmetric FIR: receives header + 9 coefficients + checksum,
// verifies the frame and commits all nine taps on one sample strobe so the filter never sees a mixed set.
module fir_coef_loader #(
  parameter int                DATA_W       = 16,
  parameter logic [DATA_W-1:0] HEADER       = 16'hC0EF,
  parameter logic [DATA_W-1:0] RESET_CENTER = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst,
  fir_coef_loader_if.slave  load,
  input  logic              sample_strobe,
  output logic [DATA_W-1:0] h0,
  output logic [DATA_W-1:0] h1,
  output logic [DATA_W-1:0] h2,
  output logic [DATA_W-1:0] h3,
  output logic [DATA_W-1:0] h4,
  output logic [DATA_W-1:0] h5,
  output logic [DATA_W-1:0] h6,
  output logic [DATA_W-1:0] h7,
  output logic [DATA_W-1:0] h8,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int NTAPS = 9;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_PENDING
  } state_t;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic [DATA_W-1:0] r_sum;
  logic [DATA_W-1:0] r_shadow [NTAPS];
  logic [DATA_W-1:0] r_h      [NTAPS];
  logic              r_ready;
  logic              r_busy;
  logic              r_done;
  logic              r_error;
  logic              w_accept;

  // Checksum is a plain 16-bit sum that wraps.
  function automatic logic [DATA_W-1:0] sum_wrap(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] s;
    s = a + b;
    return s;
  endfunction

  assign w_accept = load.load_valid && r_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
        r_shadow[i] <= '0;
        r_h[i]      <= '0;
      end
      r_h[NTAPS-1] <= RESET_CENTER;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept && load.load_data == HEADER) begin
            r_state <= S_LOAD;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          // A word equal to HEADER here is coefficient data, not a restart.
          if (w_accept) begin
            r_shadow[r_cnt] <= load.load_data;
            r_sum           <= sum_wrap(r_sum, load.load_data);
            if (r_cnt == 4'(NTAPS - 1)) begin
              r_state <= S_CHECK;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
        end
        S_CHECK: begin
          if (w_accept) begin
            if (load.load_data == r_sum) begin
              r_state <= S_PENDING;
              r_ready <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              r_error <= 1'b1;
              r_busy  <= 1'b0;
            end
          end
        end
        S_PENDING: begin
          // All nine taps move on the same strobe edge.
          if (sample_strobe) begin
            for (int i = 0; i < NTAPS; i++) begin
              r_h[i] <= r_shadow[i];
            end
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign load.load_ready = r_ready;
  assign busy  = r_busy;
  assign done  = r_done;
  assign error = r_error;
  assign h0 = r_h[0];
  assign h1 = r_h[1];
  assign h2 = r_h[2];
  assign h3 = r_h[3];
  assign h4 = r_h[4];
  assign h5 = r_h[5];
  assign h6 = r_h[6];
  assign h7 = r_h[7];
  assign h8 = r_h[8];

endmodule

// File: tb/tb_fir_coef_loader.sv
// Randomized scoreboard bench for fir_coef_loader: frames are modelled as whole transactions
// and the expected commit/error event is queued for a monitor that checks every output pulse.
module tb_fir_coef_loader;

  localparam logic [15:0] HDR = 16'hC0EF;
  localparam logic [8:0][15:0] RESET_H = {16'hFFFF, {8{16'h0000}}};

  typedef struct packed {
    logic             good;
    logic [8:0][15:0] c;
  } exp_t;

  logic clk;
  logic rst;
  logic sample_strobe;
  logic [15:0] h0, h1, h2, h3, h4, h5, h6, h7, h8;
  logic busy, done, error;

  fir_coef_loader_if #(.DATA_W(16)) lif ();

  fir_coef_loader dut (
    .clk(clk), .rst(rst), .load(lif), .sample_strobe(sample_strobe),
    .h0(h0), .h1(h1), .h2(h2), .h3(h3), .h4(h4), .h5(h5), .h6(h6), .h7(h7), .h8(h8),
    .busy(busy), .done(done), .error(error)
  );

  exp_t             sbq[$];
  logic [8:0][15:0] exp_h;
  int               errors = 0;
  int               checks = 0;
  int               cyc = 0;
  bit               mon_en = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [8:0][15:0] get_h();
    return {h8, h7, h6, h5, h4, h3, h2, h1, h0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic chk_h(input string name, input logic [8:0][15:0] req);
    logic [8:0][15:0] act;
    act = get_h();
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pops one expected event per done/error pulse, tracks the active set every cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && !rst) begin
        if (done && error) chk("done_error_overlap", 32'({done, error}), 32'b00);
        if (done || error) begin
          if (sbq.size() == 0) begin
            chk("unexpected_pulse", 32'({done, error}), 32'b00);
          end else begin
            e = sbq.pop_front();
            chk("event_kind", 32'({done, error}), e.good ? 32'b10 : 32'b01);
            if (e.good) exp_h = e.c;
          end
        end
        chk_h("h_active", exp_h);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Called right after a negedge; returns right after the negedge following acceptance.
  task automatic drive_word(input logic [15:0] w);
    int n;
    n = 0;
    lif.load_valid = 1'b1;
    lif.load_data  = w;
    while (!lif.load_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!lif.load_ready) chk("ready_timeout", 32'(lif.load_ready), 32'd1);
    @(negedge clk);
    lif.load_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    lif.load_valid = 1'b0;
    sample_strobe = 1'b0;
    sbq.delete();
    exp_h = RESET_H;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    chk_h("reset_h", RESET_H);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_error", 32'(error), 32'd0);
    chk("reset_ready", 32'(lif.load_ready), 32'd1);
  endtask

  // sdly < 0 leaves a good set pending with no strobe.
  task automatic run_frame(input logic [8:0][15:0] c, input logic [15:0] cks, input int max_gap,
                           input int sdly, input bit skip_hdr, input bit strobe_on_cks,
                           input bit offer_next);
    logic [15:0] s;
    exp_t e;
    bit   good;
    int   hc;
    s = 16'h0;
    for (int i = 0; i < 9; i++) s = s + c[i];
    good   = (s == cks);
    e.good = good;
    e.c    = c;
    sbq.push_back(e);
    hc = cyc;
    if (!skip_hdr) begin
      drive_word(HDR);
      hc = cyc;
    end
    for (int i = 0; i < 9; i++) begin
      if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) @(negedge clk);
      drive_word(c[i]);
    end
    if (strobe_on_cks) sample_strobe = 1'b1;
    drive_word(cks);
    sample_strobe = 1'b0;
    if (good) begin
      chk("ready_pending", 32'(lif.load_ready), 32'd0);
      chk("busy_pending", 32'(busy), 32'd1);
      chk("no_done_at_cks", 32'(done), 32'd0);
      if (sdly >= 0) begin
        if (offer_next) begin
          lif.load_valid = 1'b1;
          lif.load_data  = HDR;
        end
        repeat (sdly) @(negedge clk);
        if (offer_next) chk("ready_hold_pending", 32'(lif.load_ready), 32'd0);
        sample_strobe = 1'b1;
        @(negedge clk);
        sample_strobe = 1'b0;
        chk("done_at_strobe", 32'(done), 32'd1);
        chk("busy_after_commit", 32'(busy), 32'd0);
        chk("h0_committed", 32'(h0), 32'(c[0]));
        chk("h8_committed", 32'(h8), 32'(c[8]));
        if (max_gap == 0 && sdly == 0 && !skip_hdr && !strobe_on_cks)
          chk("min_latency", 32'(cyc - hc), 32'd11);
        if (offer_next) drive_word(HDR);
      end
    end else begin
      chk("error_pulse", 32'(error), 32'd1);
      chk("busy_after_error", 32'(busy), 32'd0);
      chk("ready_after_error", 32'(lif.load_ready), 32'd1);
    end
  endtask

  initial begin
    logic [8:0][15:0] c;
    logic [15:0]      s;
    bit               skip;
    bit               bad;
    bit               offer;
    rst = 1'b1;
    sample_strobe = 1'b0;
    lif.load_valid = 1'b0;
    lif.load_data  = 16'h0;
    exp_h = RESET_H;
    do_reset(2);
    mon_en = 1'b1;

    for (int i = 0; i < 9; i++) c[i] = 16'(i + 1);
    run_frame(c, 16'h002D, 0, 3, 0, 0, 0);
    run_frame(c, 16'h002C, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) c[i] = 16'(20 - i);
    run_frame(c, 16'h0084, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) c[i] = 16'(i + 1);
    run_frame(c, 16'h002D, 3, 3, 0, 0, 1);
    for (int i = 0; i < 9; i++) c[i] = 16'(16'h0100 + i);
    run_frame(c, 16'h0924, 0, 1, 1, 0, 0);

    drive_word(16'h1234);
    drive_word(16'h5678);
    for (int i = 0; i < 9; i++) c[i] = 16'(i + 1);
    c[4] = HDR;
    s = 16'h0;
    for (int i = 0; i < 9; i++) s = s + c[i];
    run_frame(c, s, 0, 2, 0, 0, 0);
    chk("h4_header_as_data", 32'(h4), 32'(HDR));

    for (int i = 0; i < 9; i++) c[i] = 16'hFFFF;
    run_frame(c, 16'hFFF7, 0, 1, 0, 0, 0);
    for (int i = 0; i < 9; i++) c[i] = 16'(16'h0030 + i);
    run_frame(c, 16'h01D4, 0, 2, 0, 1, 0);

    drive_word(HDR);
    for (int i = 0; i < 5; i++) drive_word(16'(16'h0AA0 + i));
    do_reset(1);
    for (int i = 0; i < 9; i++) c[i] = 16'(i + 1);
    run_frame(c, 16'h002D, 0, 1, 0, 0, 0);
    for (int i = 0; i < 9; i++) c[i] = 16'(16'h0200 + i);
    run_frame(c, 16'h1224, 0, -1, 0, 0, 0);
    repeat (3) @(negedge clk);
    do_reset(1);
    for (int i = 0; i < 9; i++) c[i] = 16'(16'h0010 * (i + 1));
    run_frame(c, 16'h02D0, 1, 0, 0, 0, 0);

    skip = 1'b0;
    for (int f = 0; f < 40; f++) begin
      if (!skip) begin
        repeat ($urandom_range(2, 0)) begin
          s = 16'($urandom);
          if (s == HDR) s = 16'h0000;
          drive_word(s);
        end
      end
      s = 16'h0;
      for (int i = 0; i < 9; i++) begin
        c[i] = ($urandom_range(9, 0) == 0) ? HDR : 16'($urandom);
        s = s + c[i];
      end
      bad = ($urandom_range(3, 0) == 0);
      if (bad) s = s + 16'($urandom_range(65535, 1));
      offer = !bad && ($urandom_range(4, 0) == 0);
      run_frame(c, s, $urandom_range(3, 0), $urandom_range(4, 0), skip,
                ($urandom_range(6, 0) == 0), offer);
      skip = offer;
    end

    repeat (5) @(negedge clk);
    chk("sb_drain", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
